// File: rtl/axis_realign_if.sv
// axis_realign_if: one AXI4-Stream link used by axis_realign.
//   DW     data width in bits (multiple of 8)
//   UW     tuser width
//   master : drives tvalid/tdata/tkeep/tlast/tuser, receives tready
//   slave  : receives tvalid/tdata/tkeep/tlast/tuser, drives tready
interface axis_realign_if #(
  parameter int DW = 64,
  parameter int UW = 1
);
  logic            tvalid;
  logic            tready;
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic            tlast;
  logic [UW-1:0]   tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/axis_realign.sv
// axis_realign: repacks an AXI4-Stream packet so that its first byte lands
// on output lane cfg_offset, with the rest of the bytes packed densely after
// it. Byte order is preserved (lane 0 first, beats in order).
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   cfg_offset start lane of the first output beat, sampled at packet start
//   s_axis     input stream (slave modport)
//   m_axis     output stream (master modport)
//   err_keep   one-cycle pulse after an input beat with illegal tkeep
// Storage is one output register plus a KW-byte residual buffer.
module axis_realign #(
  parameter int AXIS_DW = 64,
  parameter int USER_W  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [$clog2(AXIS_DW/8)-1:0]  cfg_offset,
  axis_realign_if.slave                 s_axis,
  axis_realign_if.master                m_axis,
  output logic                          err_keep
);

  localparam int KW = AXIS_DW / 8;
  localparam int OW = $clog2(KW);
  localparam logic [OW:0] KW_L = (OW + 1)'(KW);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t              state;
  logic                rdy_q;
  logic                err_q;
  logic [AXIS_DW-1:0]  res_data;
  logic [KW-1:0]       res_keep;
  logic [OW-1:0]       res_pos;
  logic [USER_W-1:0]   user_q;

  logic                out_valid;
  logic                out_last;
  logic [AXIS_DW-1:0]  out_data;
  logic [KW-1:0]       out_keep;
  logic [USER_W-1:0]   out_user;

  logic                out_free;
  logic                s_ready;
  logic                accept;
  logic                first;

  logic [OW-1:0]       lsb;
  logic [OW:0]         cnt;
  logic                found;
  logic [KW-1:0]       aligned_keep;
  logic                legal;
  logic [KW-1:0]       new_keep;
  logic [AXIS_DW-1:0]  shifted;
  logic [AXIS_DW-1:0]  new_data;
  logic [OW-1:0]       base_pos;
  logic [AXIS_DW-1:0]  base_data;
  logic [KW-1:0]       base_keep;
  logic [2*AXIS_DW-1:0] wide_data;
  logic [2*KW-1:0]     wide_keep;
  logic [OW:0]         total;
  logic [USER_W-1:0]   cur_user;

  assign out_free = !out_valid || m_axis.tready;
  assign s_ready  = rdy_q && (state != FLUSH) && out_free;
  assign accept   = s_axis.tvalid && s_ready;
  assign first    = (state == IDLE);
  assign cur_user = first ? s_axis.tuser : user_q;

  // Locate the valid byte run of the input beat and decide whether it is a
  // legal shape for its position in the packet. Illegal beats contribute no
  // bytes but still count for tlast.
  always_comb begin
    lsb   = '0;
    cnt   = '0;
    found = 1'b0;
    for (int i = 0; i < KW; i++) begin
      if (s_axis.tkeep[i] && !found) begin
        lsb   = OW'(i);
        found = 1'b1;
      end
      cnt = cnt + (OW + 1)'(s_axis.tkeep[i]);
    end
    aligned_keep = s_axis.tkeep >> lsb;
    // A run shifted down to lane 0 is contiguous iff it is of the form 2^n-1.
    legal = found && ((aligned_keep & (aligned_keep + 1'b1)) == '0)
            && (first || (lsb == '0))
            && (s_axis.tlast || (((OW + 1)'(lsb) + cnt) == KW_L));
    new_keep = legal ? aligned_keep : '0;
    shifted  = s_axis.tdata >> {lsb, 3'b000};
    for (int i = 0; i < KW; i++) begin
      new_data[8*i +: 8] = new_keep[i] ? shifted[8*i +: 8] : 8'h00;
    end
  end

  // Append the compacted input bytes behind whatever is already waiting in
  // the residual buffer. A new packet starts from an empty buffer whose fill
  // point is cfg_offset, which leaves the leading lanes with keep=0.
  always_comb begin
    base_pos  = first ? cfg_offset : res_pos;
    base_data = first ? '0 : res_data;
    base_keep = first ? '0 : res_keep;
    wide_data = {{AXIS_DW{1'b0}}, base_data}
              | ({{AXIS_DW{1'b0}}, new_data} << {base_pos, 3'b000});
    wide_keep = {{KW{1'b0}}, base_keep}
              | ({{KW{1'b0}}, new_keep} << base_pos);
    total     = (OW + 1)'(base_pos) + (legal ? cnt : '0);
  end

  // FLUSH lasts a single cycle: the residual beat moves into the output
  // register as soon as it is free and the FSM returns to IDLE, so the next
  // packet can start while that last beat is still being handed off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      res_data  <= '0;
      res_keep  <= '0;
      res_pos   <= '0;
      user_q    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_user  <= '0;
    end else begin
      rdy_q <= 1'b1;
      err_q <= accept && !legal;
      if (out_valid && m_axis.tready) begin
        out_valid <= 1'b0;
      end
      case (state)
        FLUSH: begin
          if (out_free) begin
            out_valid <= 1'b1;
            out_data  <= res_data;
            out_keep  <= res_keep;
            out_last  <= 1'b1;
            out_user  <= user_q;
            res_data  <= '0;
            res_keep  <= '0;
            res_pos   <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          if (accept) begin
            if (first) begin
              user_q <= s_axis.tuser;
            end
            if (s_axis.tlast) begin
              if (total > KW_L) begin
                out_valid <= 1'b1;
                out_data  <= wide_data[AXIS_DW-1:0];
                out_keep  <= wide_keep[KW-1:0];
                out_last  <= 1'b0;
                out_user  <= cur_user;
                res_data  <= wide_data[2*AXIS_DW-1:AXIS_DW];
                res_keep  <= wide_keep[2*KW-1:KW];
                res_pos   <= '0;
                state     <= FLUSH;
              end else begin
                // A packet whose bytes were all dropped emits nothing.
                if (|wide_keep[KW-1:0]) begin
                  out_valid <= 1'b1;
                  out_data  <= wide_data[AXIS_DW-1:0];
                  out_keep  <= wide_keep[KW-1:0];
                  out_last  <= 1'b1;
                  out_user  <= cur_user;
                end
                res_data <= '0;
                res_keep <= '0;
                res_pos  <= '0;
                state    <= IDLE;
              end
            end else begin
              state <= STREAM;
              if (total >= KW_L) begin
                out_valid <= 1'b1;
                out_data  <= wide_data[AXIS_DW-1:0];
                out_keep  <= wide_keep[KW-1:0];
                out_last  <= 1'b0;
                out_user  <= cur_user;
                res_data  <= wide_data[2*AXIS_DW-1:AXIS_DW];
                res_keep  <= wide_keep[2*KW-1:KW];
                res_pos   <= OW'(total - KW_L);
              end else begin
                res_data <= wide_data[AXIS_DW-1:0];
                res_keep <= wide_keep[KW-1:0];
                res_pos  <= OW'(total);
              end
            end
          end
        end
      endcase
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = out_data;
  assign m_axis.tkeep  = out_keep;
  assign m_axis.tlast  = out_last;
  assign m_axis.tuser  = out_user;
  assign err_keep      = err_q;

endmodule

// File: tb/tb_axis_realign.sv
// tb_axis_realign: directed bench for axis_realign (64-bit data, 1-bit tuser).
// Output beats are recorded by a monitor and compared against hand-computed
// beats; control outputs are checked at chosen cycles.
module tb_axis_realign;

  logic       clk;
  logic       rst_n;
  logic [2:0] cfg_offset;
  logic       err_keep;

  axis_realign_if #(.DW(64), .UW(1)) s_if ();
  axis_realign_if #(.DW(64), .UW(1)) m_if ();

  axis_realign #(.AXIS_DW(64), .USER_W(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_offset (cfg_offset),
    .s_axis     (s_if.slave),
    .m_axis     (m_if.master),
    .err_keep   (err_keep)
  );

  int tests = 0;
  int fails = 0;

  logic [63:0] cap_data [64];
  logic [7:0]  cap_keep [64];
  logic        cap_last [64];
  logic        cap_user [64];
  int          cap_n = 0;
  int          base;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every output handshake; inputs only change just after posedge.
  always @(negedge clk) begin
    if (rst_n && m_if.tvalid && m_if.tready && cap_n < 64) begin
      cap_data[cap_n[5:0]] <= m_if.tdata;
      cap_keep[cap_n[5:0]] <= m_if.tkeep;
      cap_last[cap_n[5:0]] <= m_if.tlast;
      cap_user[cap_n[5:0]] <= m_if.tuser[0];
      cap_n <= cap_n + 1;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [63:0] byte_mask(input logic [7:0] k);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input int idx,
                            input logic [63:0] ed, input logic [7:0] ek,
                            input logic el, input logic eu);
    check_output({tag, "_keep"}, 64'(cap_keep[idx[5:0]]), 64'(ek));
    check_output({tag, "_data"}, cap_data[idx[5:0]] & byte_mask(ek), ed);
    check_output({tag, "_last"}, 64'(cap_last[idx[5:0]]), 64'(el));
    check_output({tag, "_user"}, 64'(cap_user[idx[5:0]]), 64'(eu));
  endtask

  // Present one input beat and hold it until it is accepted (bounded).
  task automatic apply_stimulus(input logic [63:0] d, input logic [7:0] k,
                                input logic l, input logic u);
    int waits;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    s_if.tuser  = u;
    s_if.tvalid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!s_if.tready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    check_output("s_tready_at_accept", 64'(s_if.tready), 64'd1);
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic settle();
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    cfg_offset  = 3'd0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    m_if.tready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    check_output("rst_m_tdata", m_if.tdata, 64'd0);
    check_output("rst_m_tkeep", 64'(m_if.tkeep), 64'd0);
    check_output("rst_m_tlast", 64'(m_if.tlast), 64'd0);
    check_output("rst_m_tuser", 64'(m_if.tuser), 64'd0);
    check_output("rst_s_tready", 64'(s_if.tready), 64'd0);
    check_output("rst_err_keep", 64'(err_keep), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("rel_tready_before_edge", 64'(s_if.tready), 64'd0);
    @(posedge clk);
    #1;
    check_output("rel_tready_after_edge", 64'(s_if.tready), 64'd1);

    // Offset 0, keep F0/FF/07 (15 bytes) -> FF then 7F with tlast
    base = cap_n;
    cfg_offset = 3'd0;
    apply_stimulus(64'h04030201_DEADBEEF, 8'hF0, 1'b0, 1'b0);
    apply_stimulus(64'h0C0B0A09_08070605, 8'hFF, 1'b0, 1'b0);
    apply_stimulus(64'hAAAAAAAA_AA0F0E0D, 8'h07, 1'b1, 1'b0);
    settle();
    check_output("A_count", 64'(cap_n - base), 64'd2);
    check_beat("A0", base,     64'h08070605_04030201, 8'hFF, 1'b0, 1'b0);
    check_beat("A1", base + 1, 64'h000F0E0D_0C0B0A09, 8'h7F, 1'b1, 1'b0);

    // Offset 3, single full beat -> F8 then flush beat 07 with tlast
    base = cap_n;
    cfg_offset = 3'd3;
    apply_stimulus(64'h18171615_14131211, 8'hFF, 1'b1, 1'b0);
    check_output("B_flush_tready", 64'(s_if.tready), 64'd0);
    @(posedge clk);
    #1;
    check_output("B_after_flush_tready", 64'(s_if.tready), 64'd1);
    settle();
    check_output("B_count", 64'(cap_n - base), 64'd2);
    check_beat("B0", base,     64'h15141312_11000000, 8'hF8, 1'b0, 1'b0);
    check_beat("B1", base + 1, 64'h00000000_00181716, 8'h07, 1'b1, 1'b0);

    // Offset changes 2->5 mid-packet, tuser=1 only on first input beat
    base = cap_n;
    cfg_offset = 3'd2;
    apply_stimulus(64'h28272625_24232221, 8'hFF, 1'b0, 1'b1);
    cfg_offset = 3'd5;
    apply_stimulus(64'hBBBBBBBB_2C2B2A29, 8'h0F, 1'b1, 1'b0);
    settle();
    check_output("C_count", 64'(cap_n - base), 64'd2);
    check_beat("C0", base,     64'h26252423_22210000, 8'hFC, 1'b0, 1'b1);
    check_beat("C1", base + 1, 64'h00002C2B_2A292827, 8'h3F, 1'b1, 1'b1);

    // Backpressure: m_axis_tready low for 20 cycles mid-packet
    base = cap_n;
    cfg_offset = 3'd0;
    m_if.tready = 1'b0;
    apply_stimulus(64'h38373635_34333231, 8'hFF, 1'b0, 1'b0);
    check_output("D_tready_low", 64'(s_if.tready), 64'd0);
    s_if.tdata  = 64'h403F3E3D_3C3B3A39;
    s_if.tkeep  = 8'hFF;
    s_if.tlast  = 1'b0;
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check_output("D_hold_data", m_if.tdata, 64'h38373635_34333231);
      check_output("D_hold_valid", 64'(m_if.tvalid), 64'd1);
      check_output("D_hold_tready", 64'(s_if.tready), 64'd0);
    end
    m_if.tready = 1'b1;
    apply_stimulus(64'h403F3E3D_3C3B3A39, 8'hFF, 1'b0, 1'b0);
    apply_stimulus(64'h48474645_44434241, 8'hFF, 1'b1, 1'b0);
    settle();
    check_output("D_count", 64'(cap_n - base), 64'd3);
    check_beat("D0", base,     64'h38373635_34333231, 8'hFF, 1'b0, 1'b0);
    check_beat("D1", base + 1, 64'h403F3E3D_3C3B3A39, 8'hFF, 1'b0, 1'b0);
    check_beat("D2", base + 2, 64'h48474645_44434241, 8'hFF, 1'b1, 1'b0);

    // Illegal keep 5A with tlast, nothing else in packet -> no output
    base = cap_n;
    apply_stimulus(64'h01020304_05060708, 8'h5A, 1'b1, 1'b0);
    check_output("E_err_pulse", 64'(err_keep), 64'd1);
    @(posedge clk);
    #1;
    check_output("E_err_clear", 64'(err_keep), 64'd0);
    settle();
    check_output("E_count", 64'(cap_n - base), 64'd0);

    // Legal first beat, then illegal last beat: its tlast still closes packet
    base = cap_n;
    apply_stimulus(64'h64636261_00000000, 8'hF0, 1'b0, 1'b0);
    check_output("E2_no_err", 64'(err_keep), 64'd0);
    apply_stimulus(64'h11223344_55667788, 8'h5A, 1'b1, 1'b0);
    check_output("E2_err_pulse", 64'(err_keep), 64'd1);
    settle();
    check_output("E2_count", 64'(cap_n - base), 64'd1);
    check_beat("E2_0", base, 64'h00000000_64636261, 8'h0F, 1'b1, 1'b0);

    // Reset mid-packet discards partial data; next packet is clean
    base = cap_n;
    apply_stimulus(64'h88878685_00000000, 8'hF0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_output("F_rst_tvalid", 64'(m_if.tvalid), 64'd0);
    check_output("F_rst_tready", 64'(s_if.tready), 64'd0);
    @(posedge clk);
    #1;
    check_output("F_rst_tvalid2", 64'(m_if.tvalid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("F_rel_tready", 64'(s_if.tready), 64'd1);
    check_output("F_rel_tvalid", 64'(m_if.tvalid), 64'd0);
    check_output("F_no_output", 64'(cap_n - base), 64'd0);
    apply_stimulus(64'hFFFFFFFF_74737271, 8'h0F, 1'b1, 1'b0);
    settle();
    check_output("F_count", 64'(cap_n - base), 64'd1);
    check_beat("F0", base, 64'h00000000_74737271, 8'h0F, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
